// File: rtl/keypad_scan_if.sv
// Keypad front-end bundle: row drive / column sense lines plus the
// debounced key outputs consumed by the watch time-setting stage.
interface keypad_scan_if;
    logic [2:0] key_col;
    logic [3:0] key_row;
    logic [9:0] keypad;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_pulse;

    modport master (
        input  key_col,
        output key_row, keypad, key_code, key_valid, key_pulse
    );

    modport slave (
        output key_col,
        input  key_row, keypad, key_code, key_valid, key_pulse
    );
endinterface

// File: rtl/keypad_scan.sv
// 4x3 matrix keypad scanner: row strobing, 2-flop column synchronizer,
// per-frame single-key decode and a frame-stepped debounce FSM.
module keypad_scan #(
    parameter int ROW_HOLD        = 4,
    parameter int DEBOUNCE_FRAMES = 3
) (
    input  logic           clk,
    input  logic           rst,
    keypad_scan_if.master  bus
);
    localparam int HW = $clog2(ROW_HOLD);
    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [3:0] NONE = 4'd15;

    typedef enum logic [1:0] {RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    logic [2:0]    col_s1, col_s2;
    logic [1:0]    row, row_nx;
    logic [HW-1:0] hold;
    logic          sample, frame_end;

    function automatic logic [3:0] key_map(input logic [1:0] r, input int c);
        if (r == 2'd3) return (c == 0) ? 4'd10 : (c == 1) ? 4'd0 : 4'd11;
        return 4'(3 * int'(r) + c + 1);
    endfunction

    assign sample    = (hold == HW'(ROW_HOLD - 1));
    assign frame_end = sample && (row == 2'd3);
    assign row_nx    = sample ? row + 2'd1 : row;

    // key_row follows the next row index so the drive lines up with row/hold,
    // leaving ROW_HOLD-1 cycles for the synchronizer to settle before sampling.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_s1      <= 3'b111;
            col_s2      <= 3'b111;
            row         <= '0;
            hold        <= '0;
            bus.key_row <= 4'b1111;
        end else begin
            col_s1      <= bus.key_col;
            col_s2      <= col_s1;
            hold        <= sample ? '0 : hold + 1'b1;
            row         <= row_nx;
            bus.key_row <= ~(4'b0001 << row_nx);
        end
    end

    // hits saturate at 2: anything beyond one closed key is rejected
    logic [1:0] row_hits, acc_hits, tot_hits;
    logic [3:0] row_code, acc_code, tot_code, frame_code;
    logic [2:0] hit_sum;

    always_comb begin
        row_hits = '0;
        row_code = NONE;
        for (int c = 0; c < 3; c++) begin
            if (!col_s2[c]) begin
                row_hits = (row_hits == 2'd0) ? 2'd1 : 2'd2;
                row_code = key_map(row, c);
            end
        end
        hit_sum    = {1'b0, acc_hits} + {1'b0, row_hits};
        tot_hits   = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
        tot_code   = (row_hits != 2'd0) ? row_code : acc_code;
        frame_code = (tot_hits == 2'd1) ? tot_code : NONE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_hits <= '0;
            acc_code <= NONE;
        end else if (frame_end) begin
            acc_hits <= '0;
            acc_code <= NONE;
        end else if (sample) begin
            acc_hits <= tot_hits;
            acc_code <= tot_code;
        end
    end

    state_t        state, state_nx;
    logic [3:0]    cand, cand_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          load, clear;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RELEASED;
            cand  <= NONE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cand  <= cand_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cand_nx  = cand;
        cnt_nx   = cnt;
        if (frame_end) begin
            case (state)
                RELEASED: if (frame_code != NONE) begin
                    state_nx = PRESS_WAIT;
                    cand_nx  = frame_code;
                    cnt_nx   = CW'(1);
                end
                PRESS_WAIT: begin
                    if (frame_code == cand) begin
                        cnt_nx = cnt + 1'b1;
                        if (cnt_nx == CW'(DEBOUNCE_FRAMES)) state_nx = PRESSED;
                    end else if (frame_code == NONE) begin
                        state_nx = RELEASED;
                    end else begin
                        cand_nx = frame_code;
                        cnt_nx  = CW'(1);
                    end
                end
                PRESSED: if (frame_code != cand) begin
                    state_nx = RELEASE_WAIT;
                    cnt_nx   = CW'(1);
                end
                RELEASE_WAIT: begin
                    if (frame_code == cand) begin
                        state_nx = PRESSED;
                    end else begin
                        cnt_nx = cnt + 1'b1;
                        if (cnt_nx == CW'(DEBOUNCE_FRAMES)) state_nx = RELEASED;
                    end
                end
                default: state_nx = RELEASED;
            endcase
        end
    end

    always_comb begin
        load  = (state == PRESS_WAIT)   && (state_nx == PRESSED);
        clear = (state == RELEASE_WAIT) && (state_nx == RELEASED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.keypad    <= '0;
            bus.key_code  <= NONE;
            bus.key_valid <= 1'b0;
            bus.key_pulse <= 1'b0;
        end else begin
            bus.key_pulse <= load;
            if (load) begin
                bus.key_code  <= cand;
                bus.key_valid <= 1'b1;
                bus.keypad    <= (cand <= 4'd9) ? (10'd1 << cand) : '0;
            end else if (clear) begin
                bus.key_code  <= NONE;
                bus.key_valid <= 1'b0;
                bus.keypad    <= '0;
            end
        end
    end
endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: switch-matrix model driven frame by frame, checked
// against a streak-counting debounce model plus random-phase latency runs.
module tb_keypad_scan;
    localparam int D = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    keypad_scan_if kif();
    keypad_scan #(.ROW_HOLD(4), .DEBOUNCE_FRAMES(D)) dut (.clk(clk), .rst(rst), .bus(kif));

    // pressed[r*3+c]: switch closed at row r, column c
    logic [11:0] pressed = '0;
    logic [2:0]  col;
    always_comb begin
        col = 3'b111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (pressed[r*3+c] && !kif.key_row[r]) col[c] = 1'b0;
    end
    assign kif.key_col = col;

    int vectors = 0, errors = 0, n = 0;
    int map[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};
    int m_held = 15, m_run = 0, m_rc = 15, m_miss = 0;
    bit m_pulse = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, n);
        end
    endtask

    // 99 stands for the '1'+'9' double press
    function automatic logic [11:0] set_of(input int code);
        logic [11:0] s = '0;
        if (code == 99) begin
            s[0] = 1'b1;
            s[8] = 1'b1;
        end else if (code != 15) begin
            for (int p = 0; p < 12; p++) if (map[p] == code) s[p] = 1'b1;
        end
        return s;
    endfunction

    function automatic int frame_code_of(input logic [11:0] s);
        if ($countones(s) != 1) return 15;
        for (int p = 0; p < 12; p++) if (s[p]) return map[p];
        return 15;
    endfunction

    // press = D identical valid frames in a row while idle;
    // release = D frames in a row not showing the held key
    task automatic model_frame(input int fc);
        m_pulse = 1'b0;
        if (m_held == 15) begin
            if (fc == 15) m_run = 0;
            else if (fc == m_rc && m_run > 0) m_run++;
            else begin
                m_rc  = fc;
                m_run = 1;
            end
            if (m_run == D) begin
                m_held  = fc;
                m_pulse = 1'b1;
                m_miss  = 0;
            end
        end else if (fc == m_held) begin
            m_miss = 0;
        end else begin
            m_miss++;
            if (m_miss == D) begin
                m_held = 15;
                m_run  = 0;
            end
        end
    endtask

    task automatic model_reset();
        m_held = 15; m_run = 0; m_rc = 15; m_miss = 0; m_pulse = 1'b0;
    endtask

    task automatic step();
        logic [3:0] exp_row;
        @(posedge clk);
        @(negedge clk);
        n++;
        exp_row = 4'b1111 ^ (4'b0001 << ((n % 16) / 4));
        check("key_row", {28'd0, kif.key_row}, {28'd0, exp_row});
    endtask

    task automatic run_frame(input int code);
        logic [9:0] exp_kp;
        pressed = set_of(code);
        for (int i = 1; i <= 16; i++) begin
            step();
            if (i < 16) check("pulse_idle", {31'd0, kif.key_pulse}, 32'd0);
        end
        model_frame(frame_code_of(pressed));
        exp_kp = (m_held <= 9) ? (10'd1 << m_held) : 10'd0;
        check("key_pulse", {31'd0, kif.key_pulse}, {31'd0, m_pulse});
        check("key_valid", {31'd0, kif.key_valid}, (m_held != 15) ? 32'd1 : 32'd0);
        check("key_code",  {28'd0, kif.key_code}, m_held);
        check("keypad",    {22'd0, kif.keypad}, {22'd0, exp_kp});
    endtask

    task automatic run_code(input int code, input int frames);
        for (int f = 0; f < frames; f++) run_frame(code);
    endtask

    task automatic check_cleared(input string tag);
        check(tag, {kif.key_row, kif.keypad, kif.key_code, kif.key_valid, kif.key_pulse},
              {4'b1111, 10'd0, 4'd15, 1'b0, 1'b0});
    endtask

    initial begin
        int choices[14] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 15, 99};
        int lat, pulses;

        // reset and idle scan
        repeat (5) @(negedge clk);
        check_cleared("reset_state");
        rst = 1'b1;
        n = 0;
        run_code(15, 2);

        // clean press/release of '5', bounce on '0', double press, '*', '#'
        run_code(5, 4);
        run_code(15, 4);
        for (int k = 0; k < 4; k++) begin
            run_frame(0);
            run_frame(15);
        end
        run_code(0, 4);
        run_code(15, 4);
        run_code(99, 10);
        run_code(10, 4);
        run_code(15, 4);
        run_code(11, 4);
        run_code(15, 4);

        // change held key without release, then glitches on a held key
        run_code(5, 4);
        run_code(6, 7);
        run_frame(15);
        run_frame(6);
        run_frame(99);
        run_frame(2);
        run_frame(6);
        run_code(15, 4);

        // random runs
        for (int k = 0; k < 30; k++)
            run_code(choices[$urandom_range(0, 13)], $urandom_range(1, 5));
        run_code(15, 4);

        // press latency from a random phase
        repeat ($urandom_range(0, 15)) step();
        pressed = set_of(8);
        lat = -1;
        pulses = 0;
        for (int i = 1; i <= 80; i++) begin
            step();
            if (kif.key_pulse) begin
                pulses++;
                if (lat < 0) lat = i;
            end
        end
        check("press_latency_ok", (lat >= 32 && lat <= 67) ? 32'd1 : 32'd0, 32'd1);
        check("press_pulses", pulses, 32'd1);
        check("press_keypad", {22'd0, kif.keypad}, 32'h100);

        // release latency from a random phase
        repeat ($urandom_range(0, 15)) step();
        pressed = '0;
        lat = -1;
        for (int i = 1; i <= 80 && lat < 0; i++) begin
            step();
            if (!kif.key_valid) lat = i;
        end
        check("release_latency_ok", (lat >= 32 && lat <= 67) ? 32'd1 : 32'd0, 32'd1);
        check("release_code", {28'd0, kif.key_code}, 32'd15);
        while (n % 16 != 0) step();
        model_reset();
        run_code(15, 1);

        // reset while '7' is held
        run_code(7, 4);
        repeat (5) step();
        rst = 1'b0;
        #1;
        check_cleared("reset_mid_press");
        repeat (3) @(negedge clk);
        check_cleared("reset_held");
        rst = 1'b1;
        n = 0;
        model_reset();
        run_code(7, 5);
        run_code(15, 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/keypad_scan.md
# keypad_scan

Matrix-keypad front end for the digital watch. Drives the rows of a 4×3 keypad and samples its columns, then debounces the result. It outputs the level-style one-hot `keypad[9:0]` vector that the watch/time-setting stage consumes on its `keypad` input, plus a key code and a one-cycle press strobe. It runs on the same 1 kHz system clock as the watch.

## Interface
- `ROW_HOLD`, default 4: cycles each row is held low. Legal values are ≥3.
- `DEBOUNCE_FRAMES`, default 3: consecutive identical scan frames required to accept a press or a release. Legal values are ≥2.
- `clk`  in  1  1 kHz system clock; all logic on the rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `key_col`  in  3  column sense lines; active-low, pulled up externally, asynchronous to `clk`.
- `key_row`  out  4  row drive; active-low, at most one bit low at a time.
- `keypad`  out  10  one-hot level of the held digit key (bit n = digit n); all zero otherwise.
- `key_code`  out  4  held key code: 0–9 for digits, 10 for `*`, 11 for `#`, 15 for none.
- `key_valid`  out  1  high while a debounced key is held.
- `key_pulse`  out  1  one-cycle strobe on each accepted press.

## Operation
- **Key map** (row, col):
  - r0: 1, 2, 3
  - r1: 4, 5, 6
  - r2: 7, 8, 9
  - r3: `*`, 0, `#`
- **Synchronizer:** `key_col` passes through a 2-flop synchronizer before any use.
- **Scanner:**
  - Row index 0→1→2→3→0; hold counter 0..ROW_HOLD-1.
  - `key_row` = ~(1<<row).
  - Synchronized columns are sampled on the hold count ROW_HOLD-1. The 2-flop delay is why ROW_HOLD ≥3.
- **Frame:** 4·ROW_HOLD cycles. The frame ends on the last sample of row 3.
- **frame_code** is computed from the 4 row samples:
  - Exactly one key closed across the whole frame: that key's code.
  - No key closed: 15.
  - Two or more keys closed: 15 (ghost/multi-press rejection).
- **Debounce FSM** steps only at frame end. `cand` is the candidate code, `cnt` the frame counter.
  - `RELEASED`: frame_code≠15 → `PRESS_WAIT`, cand=code, cnt=1.
  - `PRESS_WAIT`:
    - code==cand: cnt+1. On reaching DEBOUNCE_FRAMES → `PRESSED`, and the outputs are loaded.
    - code==15: → `RELEASED`.
    - Other valid code: stay, cand=code, cnt=1.
  - `PRESSED`: code==cand → stay. Otherwise → `RELEASE_WAIT`, cnt=1.
  - `RELEASE_WAIT`:
    - code==cand: → `PRESSED`. Outputs are unchanged and there is no new pulse.
    - Otherwise: cnt+1. On reaching DEBOUNCE_FRAMES → `RELEASED`, and the outputs are cleared.
- **Outputs on entering `PRESSED`:**
  - `key_code`=cand and `key_valid`=1.
  - `keypad`=1<<cand if cand≤9, else all zero.
  - `key_pulse`=1 for exactly one cycle.
- **Outputs on entering `RELEASED` from `RELEASE_WAIT`:** `keypad`=0, `key_code`=15, `key_valid`=0.
- **Key changed while held** (e.g. 5→6 without a release): treated as release then press. Key 6 takes ≥DEBOUNCE_FRAMES frames to release plus DEBOUNCE_FRAMES frames to press.
- `key_pulse` never asserts twice without an intervening `RELEASED`.

## Timing
- **Reset values:**
  - `key_row`=4'b1111; row=0, hold=0; synchronizer flops=3'b111.
  - `keypad`=0, `key_code`=15, `key_valid`=0, `key_pulse`=0.
  - FSM=`RELEASED`, cnt=0, cand=15.
- First rising edge after `rst` deasserts drives `key_row`=4'b1110.
- Reset asserted mid-scan or mid-debounce returns all state to the reset values asynchronously. No pulse is emitted.
- All outputs are registered and update on the cycle after the frame-end edge.
- **Press latency:** key closed and stable from cycle t. `key_pulse` is asserted within (DEBOUNCE_FRAMES+1)·4·ROW_HOLD+3 cycles: ≤67 with defaults, ≥(DEBOUNCE_FRAMES-1)·4·ROW_HOLD cycles.
- **Release latency:** same bound as press latency.
- **Bounce tolerance:** any contact glitch confined to fewer than DEBOUNCE_FRAMES consecutive frames produces no pulse and no change to a held key.
- Counter widths are sized from the parameters; no wrap occurs inside legal ranges.

## Test plan
- **Reset and scan:** hold `rst`=0 for 5 cycles, then release. All outputs are at reset values. `key_row` cycles 1110, 1101, 1011, 0111, each for 4 cycles, and repeats with period 16.
- **Clean press of '5':** model ground r1/c1. `keypad`=10'b0000100000, `key_code`=5, `key_valid`=1, a single `key_pulse`, all within 67 cycles. After release, all clear within 67 cycles.
- **Bounce:** press '0' but open the contact for 1 frame in every 2. No `key_pulse` occurs. Then hold stably: exactly one pulse, `keypad`=10'b0000000001.
- **Two keys:** press '1' and '9' simultaneously for 10 frames. `key_valid` stays 0 and there is no pulse.
- **Star/hash:** press `*` → `key_code`=10, `keypad`=0, `key_valid`=1, one pulse. Repeat with `#` → `key_code`=11.
- **Reset mid-press:** assert `rst` while in `PRESSED` with '7' held. Outputs clear immediately. After deassert with '7' still held, a fresh single pulse occurs after the debounce period.
